// File: rtl/l2_pkg.sv
// Shared types for the set-associative L2: line coherence states, the latched
// bus request flags and the controller state encoding.
package l2_pkg;

    typedef enum logic [1:0] {
        L2_I = 2'd0,
        L2_C = 2'd1,
        L2_D = 2'd2
    } l2_state_t;

    // Request attributes that survive past the bus handshake.
    typedef struct packed {
        logic rw;
    } bus_req_t;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWb,
        StFillReq,
        StFillWait,
        StResp
    } l2_fsm_t;

endpackage

// File: rtl/l2_assoc_array.sv
// Line storage for SETS x WAYS lines plus one round-robin pointer per set.
// Lookup is combinational; the single write port and pointer advance are
// registered.
module l2_assoc_array
    import l2_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned TAG_BITS   = 2,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_BITS  = 1,
    parameter int unsigned WAY_BITS   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    // lookup port
    input  logic [INDEX_BITS-1:0] rd_index_i,
    input  logic [TAG_BITS-1:0]   rd_tag_i,
    output logic [WAYS-1:0]       hit_vec_o,
    output logic [WAY_BITS-1:0]   hit_way_o,
    output logic [LINE_BITS-1:0]  hit_data_o,
    output logic [WAY_BITS-1:0]   victim_way_o,
    output logic                  victim_rr_o,
    output l2_state_t             victim_state_o,
    output logic [TAG_BITS-1:0]   victim_tag_o,
    output logic [LINE_BITS-1:0]  victim_data_o,
    // write port
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic [WAY_BITS-1:0]   wr_way_i,
    input  l2_state_t             wr_state_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [LINE_BITS-1:0]  wr_data_i,
    // round-robin pointer advance
    input  logic                  ptr_adv_i,
    input  logic [INDEX_BITS-1:0] ptr_index_i
);

    localparam int unsigned SETS = 1 << INDEX_BITS;

    typedef struct packed {
        l2_state_t             state;
        logic [TAG_BITS-1:0]   tag;
        logic [LINE_BITS-1:0]  data;
    } line_t;

    line_t               lines_q [SETS][WAYS];
    logic [WAY_BITS-1:0] ptr_q   [SETS];
    logic [WAY_BITS-1:0] victim_way;
    line_t               wr_line;
    line_t               victim_line;

    // Tag compare across the set and victim choice (lowest invalid way, else pointer).
    always_comb begin
        hit_vec_o   = '0;
        hit_way_o   = '0;
        hit_data_o  = '0;
        victim_rr_o = 1'b1;
        victim_way  = ptr_q[rd_index_i];
        // Descending scan so the lowest-numbered matching way wins.
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (lines_q[rd_index_i][w].state == L2_I) begin
                victim_rr_o = 1'b0;
                victim_way  = WAY_BITS'(w);
            end else if (lines_q[rd_index_i][w].tag == rd_tag_i) begin
                hit_vec_o[w] = 1'b1;
                hit_way_o    = WAY_BITS'(w);
                hit_data_o   = lines_q[rd_index_i][w].data;
            end
        end
        victim_line    = lines_q[rd_index_i][victim_way];
        victim_way_o   = victim_way;
        victim_state_o = victim_line.state;
        victim_tag_o   = victim_line.tag;
        victim_data_o  = victim_line.data;
    end

    // Pack the write port into one line record.
    always_comb begin
        wr_line = '{state: wr_state_i, tag: wr_tag_i, data: wr_data_i};
    end

    // Storage update; reset invalidates every line and rewinds every pointer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s < int'(SETS); s++) begin
                ptr_q[s] <= '0;
                for (int w = 0; w < int'(WAYS); w++) begin
                    lines_q[s][w] <= '{state: L2_I, tag: '0, data: '0};
                end
            end
        end else begin
            if (we_i) begin
                lines_q[wr_index_i][wr_way_i] <= wr_line;
            end
            if (ptr_adv_i) begin
                // WAYS is a power of two, so plain increment wraps mod WAYS.
                ptr_q[ptr_index_i] <= (WAYS > 1) ? ptr_q[ptr_index_i] + WAY_BITS'(1) : '0;
            end
        end
    end

endmodule

// File: rtl/l2_assoc_cache.sv
// N-way set-associative write-back L2. One outstanding line request from the
// bus; misses write back a dirty victim, then fill (reads) or install the
// full-line write directly.
module l2_assoc_cache
    import l2_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 6,
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_BITS  = 1,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 l2_req_valid_i,
    output logic                 l2_req_ready_o,
    input  logic [ADDR_BITS-1:0] l2_req_addr_i,
    input  logic                 l2_req_rw_i,
    input  logic [LINE_BITS-1:0] l2_req_data_i,
    output logic                 l2_resp_valid_o,
    output logic [LINE_BITS-1:0] l2_resp_data_o,
    output logic                 mem_req_valid_o,
    output logic                 mem_req_rw_o,
    output logic [ADDR_BITS-1:0] mem_req_addr_o,
    output logic [LINE_BITS-1:0] mem_req_data_o,
    input  logic                 mem_req_ready_i,
    input  logic                 mem_resp_valid_i,
    input  logic [LINE_BITS-1:0] mem_resp_data_i,
    output logic [CNT_BITS-1:0]  hit_count_o,
    output logic [CNT_BITS-1:0]  miss_count_o
);

    localparam int unsigned TAG_BITS = ADDR_BITS - INDEX_BITS;
    localparam int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

    l2_fsm_t              state_q;
    bus_req_t             req_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LINE_BITS-1:0] data_q;
    logic [WAY_BITS-1:0]  victim_way_q;

    logic                 ready_q;
    logic                 resp_valid_q;
    logic [LINE_BITS-1:0] resp_data_q;
    logic                 mreq_valid_q;
    logic                 mreq_rw_q;
    logic [ADDR_BITS-1:0] mreq_addr_q;
    logic [LINE_BITS-1:0] mreq_data_q;
    logic [CNT_BITS-1:0]  hit_cnt_q;
    logic [CNT_BITS-1:0]  miss_cnt_q;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [WAYS-1:0]       hit_vec;
    logic                  hit;
    logic [WAY_BITS-1:0]   hit_way;
    logic [LINE_BITS-1:0]  hit_data;
    logic [WAY_BITS-1:0]   victim_way;
    logic                  victim_rr;
    l2_state_t             victim_state;
    logic [TAG_BITS-1:0]   victim_tag;
    logic [LINE_BITS-1:0]  victim_data;

    logic                  arr_we;
    logic [WAY_BITS-1:0]   arr_way;
    l2_state_t             arr_state;
    logic [LINE_BITS-1:0]  arr_data;
    logic                  ptr_adv;

    assign index = addr_q[INDEX_BITS-1:0];
    assign tag   = addr_q[ADDR_BITS-1:INDEX_BITS];
    assign hit   = |hit_vec;

    l2_assoc_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .WAYS       (WAYS),
        .LINE_BITS  (LINE_BITS),
        .WAY_BITS   (WAY_BITS)
    ) u_array (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .rd_index_i     (index),
        .rd_tag_i       (tag),
        .hit_vec_o      (hit_vec),
        .hit_way_o      (hit_way),
        .hit_data_o     (hit_data),
        .victim_way_o   (victim_way),
        .victim_rr_o    (victim_rr),
        .victim_state_o (victim_state),
        .victim_tag_o   (victim_tag),
        .victim_data_o  (victim_data),
        .we_i           (arr_we),
        .wr_index_i     (index),
        .wr_way_i       (arr_way),
        .wr_state_i     (arr_state),
        .wr_tag_i       (tag),
        .wr_data_i      (arr_data),
        .ptr_adv_i      (ptr_adv),
        .ptr_index_i    (index)
    );

    // Array write and pointer strobes, decoded from the current state.
    always_comb begin
        arr_we    = 1'b0;
        arr_way   = victim_way_q;
        arr_state = L2_D;
        arr_data  = data_q;
        ptr_adv   = 1'b0;
        unique case (state_q)
            StLookup: begin
                if (hit) begin
                    arr_we  = req_q.rw;
                    arr_way = hit_way;
                end else begin
                    // Filling an invalid way leaves the pointer alone.
                    ptr_adv = victim_rr;
                    if (req_q.rw && victim_state != L2_D) begin
                        arr_we  = 1'b1;
                        arr_way = victim_way;
                    end
                end
            end
            // mem_req_valid is held high for the whole of StWb.
            StWb: arr_we = req_q.rw && mem_req_ready_i;
            StFillWait: begin
                arr_we    = mem_resp_valid_i;
                arr_state = L2_C;
                arr_data  = mem_resp_data_i;
            end
            default: ;
        endcase
    end

    // Controller: request latch, memory handshake, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            req_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            victim_way_q <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            mreq_valid_q <= 1'b0;
            mreq_rw_q    <= 1'b0;
            mreq_addr_q  <= '0;
            mreq_data_q  <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ready_q && l2_req_valid_i) begin
                        req_q.rw <= l2_req_rw_i;
                        addr_q   <= l2_req_addr_i;
                        data_q   <= l2_req_data_i;
                        ready_q  <= 1'b0;
                        state_q  <= StLookup;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                StLookup: begin
                    if (hit) begin
                        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
                        resp_data_q  <= req_q.rw ? data_q : hit_data;
                        resp_valid_q <= 1'b1;
                        state_q      <= StResp;
                    end else begin
                        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
                        victim_way_q <= victim_way;
                        if (victim_state == L2_D) begin
                            mreq_valid_q <= 1'b1;
                            mreq_rw_q    <= 1'b1;
                            mreq_addr_q  <= {victim_tag, index};
                            mreq_data_q  <= victim_data;
                            state_q      <= StWb;
                        end else if (req_q.rw) begin
                            resp_data_q  <= data_q;
                            resp_valid_q <= 1'b1;
                            state_q      <= StResp;
                        end else begin
                            mreq_valid_q <= 1'b1;
                            mreq_rw_q    <= 1'b0;
                            mreq_addr_q  <= addr_q;
                            state_q      <= StFillReq;
                        end
                    end
                end
                StWb: begin
                    if (mem_req_ready_i) begin
                        if (req_q.rw) begin
                            mreq_valid_q <= 1'b0;
                            resp_data_q  <= data_q;
                            resp_valid_q <= 1'b1;
                            state_q      <= StResp;
                        end else begin
                            // Valid stays high; the fill request follows back to back.
                            mreq_rw_q   <= 1'b0;
                            mreq_addr_q <= addr_q;
                            state_q     <= StFillReq;
                        end
                    end
                end
                StFillReq: begin
                    if (mem_req_ready_i) begin
                        mreq_valid_q <= 1'b0;
                        state_q      <= StFillWait;
                    end
                end
                StFillWait: begin
                    if (mem_resp_valid_i) begin
                        resp_data_q  <= mem_resp_data_i;
                        resp_valid_q <= 1'b1;
                        state_q      <= StResp;
                    end
                end
                StResp: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign l2_req_ready_o  = ready_q;
    assign l2_resp_valid_o = resp_valid_q;
    assign l2_resp_data_o  = resp_data_q;
    assign mem_req_valid_o = mreq_valid_q;
    assign mem_req_rw_o    = mreq_rw_q;
    assign mem_req_addr_o  = mreq_addr_q;
    assign mem_req_data_o  = mreq_data_q;
    assign hit_count_o     = hit_cnt_q;
    assign miss_count_o    = miss_cnt_q;

endmodule

// File: doc/l2_assoc_cache.md
# l2_assoc_cache

Parametrised, N-way set-associative successor to the direct-mapped L2 in the bus/memory path of the multicore cache system. It accepts one line-granular request at a time from the snooping bus and serves hits locally. On a miss it picks a victim, writes it back to main memory if dirty, and fills from memory. It adds write-allocate without fill on full-line writes, round-robin replacement, and saturating hit/miss counters.

## Interface
- ADDR_BITS, 6: line address width; TAG_BITS = ADDR_BITS - INDEX_BITS.
- INDEX_BITS, 4: set index width; SETS = 2**INDEX_BITS.
- WAYS, 2: associativity, power of two, at least 1.
- LINE_BITS, 1: cacheline data width.
- CNT_BITS, 16: width of the statistics counters.
- clk  in  1  single clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- l2_req_valid  in  1  bus request valid.
- l2_req_ready  out  1  request accepted when valid & ready.
- l2_req_addr  in  ADDR_BITS  line address, split as {tag, index}.
- l2_req_rw  in  1  0 = read, 1 = full-line write.
- l2_req_data  in  LINE_BITS  write data.
- l2_resp_valid  out  1  one-cycle completion pulse, for reads and writes.
- l2_resp_data  out  LINE_BITS  read data, or the written data on a write.
- mem_req_valid  out  1  memory request valid.
- mem_req_rw  out  1  0 = fill read, 1 = writeback.
- mem_req_addr  out  ADDR_BITS  memory line address.
- mem_req_data  out  LINE_BITS  writeback data.
- mem_req_ready  in  1  memory accepts the request when valid & ready.
- mem_resp_valid  in  1  fill data valid. Ignored outside FILL_WAIT.
- mem_resp_data  in  LINE_BITS  fill data.
- hit_count  out  CNT_BITS  saturating count of lookup hits.
- miss_count  out  CNT_BITS  saturating count of lookup misses.

## Operation
- FSM states: IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT, RESP.
- IDLE
  - l2_req_ready = 1.
  - On handshake, latch addr, rw and data, then go to LOOKUP.
- LOOKUP (1 cycle)
  - Compare the tag against every way of the set whose state is not L2_I.
  - Read hit: resp_data = line; go to RESP.
  - Write hit: line gets the new data and state L2_D; go to RESP.
  - Increment hit_count or miss_count, saturating at all-ones.
- Victim selection on a miss
  - The lowest-numbered invalid way, if any.
  - Otherwise the set's round-robin pointer. The pointer then advances by 1 mod WAYS.
  - The pointer does not move when an invalid way is filled.
  - Victim in L2_D: go to WB. Otherwise go to FILL_REQ (read) or install directly (write).
- WB
  - mem_req_valid = 1, rw = 1, addr = {victim tag, index}, data = victim line.
  - Hold until mem_req_ready.
  - Then go to FILL_REQ (read) or install (write).
- Write miss
  - No fill.
  - Install {L2_D, tag, req_data} into the victim way; go to RESP.
- FILL_REQ
  - mem_req_valid = 1, rw = 0, addr = latched address. Hold until mem_req_ready, then go to FILL_WAIT.
- FILL_WAIT
  - On mem_resp_valid, install {L2_C, tag, mem_resp_data}.
  - resp_data = mem_resp_data; go to RESP.
- RESP
  - l2_resp_valid = 1 for exactly one cycle, then go to IDLE.
- Line states are L2_I, L2_C and L2_D only. A tag hit never coexists in two ways.

## Timing
- Reset values
  - Every output is 0 while reset is high, including l2_req_ready.
  - The FSM is in IDLE.
  - All lines are L2_I.
  - All round-robin pointers and both counters are 0.
- Hit latency
  - Accept at cycle 0, LOOKUP at cycle 1, l2_resp_valid at cycle 2.
  - l2_req_ready is back at cycle 3.
- Clean read miss with a zero-wait memory
  - mem_req_valid at cycle 2, mem_resp_valid at cycle N.
  - l2_resp_valid at cycle N+1.
- mem_req_* outputs are stable while valid is high and ready is low.
- l2_req_ready is 0 in every state except IDLE. There is only one outstanding request.
- Reset mid-operation (any state)
  - On the next edge the FSM returns to IDLE and the array is invalidated.
  - Any pending memory transaction is abandoned.
  - A stale mem_resp_valid arriving afterwards is ignored.
- Counters hold at 2**CNT_BITS - 1 and never wrap.

## Structure
- Shared package l2_pkg holds:
  - l2_state_t {L2_I, L2_C, L2_D}.
  - bus_req_t.
  - The FSM state enum l2_fsm_t.
- Line struct {state, tag, data} is built from the parameters inside the module.
- Sub-module l2_assoc_array
  - Holds SETS×WAYS line storage and the per-set round-robin pointers.
  - Combinational read port: hit vector, hit way, victim way, victim line.
  - One synchronous write port plus a pointer-advance strobe.
  - Synchronous reset.
- Top level
  - Contains the FSM, request latch, memory handshake and counters.

## Test plan
Test defaults: WAYS=2, INDEX_BITS=4, ADDR_BITS=6.
- Read miss, then hit
  - Read 0x05 with memory returning 1 -> mem read addr 0x05, resp_data 1.
  - Re-read 0x05 -> resp at cycle 2, no memory activity.
  - hit_count=1, miss_count=1.
- Write miss into a free way
  - Write 0x15 data 0 after the test above -> no memory traffic.
  - Line installed dirty in way 1, resp_valid pulse with resp_data 0.
- Replacement in set 5
  - Write 0x25 -> evicts clean 0x05 from way 0 with no writeback; pointer becomes 1.
  - Write 0x35 -> memory write addr 0x15 data 0, then install in way 1.
- Backpressure
  - Hold mem_req_ready low for 5 cycles during a fill -> mem_req_valid, addr and rw stable.
  - l2_req_ready stays 0; response arrives after ready rises.
- Reset in FILL_WAIT
  - Reset for 1 cycle -> mem_req_valid 0, l2_req_ready 1 after deassertion.
  - A later mem_resp_valid is ignored; re-reading the address misses.
- Counter saturation
  - With CNT_BITS=2, five hits -> hit_count holds at 3.
